// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small FWFT FIFO buffering signed ALU results.
// The ALU ignore code is dropped on accept. Two saturating 8-bit counters track
// stored boundary results and dropped ignore codes.
module alu_result_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int IGN_CODE   = -32,
  parameter int POS_LIM    = 30,
  parameter int NEG_LIM    = -30
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                in_valid,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  output logic                                in_ready,
  output logic                                out_valid,
  output logic signed [DATA_WIDTH-1:0]        out_data,
  input  logic                                out_ready,
  output logic        [$clog2(DEPTH):0]       count,
  output logic                                full,
  output logic                                empty,
  output logic        [7:0]                   sat_count,
  output logic        [7:0]                   ign_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic signed [DATA_WIDTH-1:0] IGN_V = IGN_CODE[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] POS_V = POS_LIM[DATA_WIDTH-1:0];
  localparam logic signed [DATA_WIDTH-1:0] NEG_V = NEG_LIM[DATA_WIDTH-1:0];
  localparam logic        [CW-1:0]         FULL_CNT = CW'(DEPTH);

  // Event counters stick at their maximum instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic        [AW-1:0]         rd_ptr;
  logic        [AW-1:0]         wr_ptr;

  logic accept;
  logic is_ign;
  logic is_lim;
  logic store;
  logic pop;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign accept = in_valid && in_ready;
  assign is_ign = (in_data == IGN_V);
  assign is_lim = (in_data == POS_V) || (in_data == NEG_V);
  assign store  = accept && !is_ign;
  assign pop    = out_valid && out_ready;

  // Pointer, occupancy and event counter control; clr overrides every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sat_count <= '0;
      ign_count <= '0;
    end else if (clr) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      sat_count <= '0;
      ign_count <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (store && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !store) begin
        count <= count - 1'b1;
      end
      if (store && is_lim) begin
        sat_count <= sat_inc(sat_count);
      end
      if (accept && is_ign) begin
        ign_count <= sat_inc(ign_count);
      end
    end
  end

  // Storage array; data is not reset, only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (store && !clr) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DATA_WIDTH=6, DEPTH=4).
module tb_alu_result_fifo;

  logic              clk;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic signed [5:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic signed [5:0] out_data;
  logic              out_ready;
  logic        [2:0] count;
  logic              full;
  logic              empty;
  logic        [7:0] sat_count;
  logic        [7:0] ign_count;

  int checks = 0;
  int errors = 0;

  alu_result_fifo #(
    .DATA_WIDTH(6), .DEPTH(4), .IGN_CODE(-32), .POS_LIM(30), .NEG_LIM(-30)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty),
    .sat_count(sat_count), .ign_count(ign_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one value for exactly one clock edge.
  task automatic push(input logic signed [5:0] v);
    in_valid = 1'b1;
    in_data  = v;
    cyc();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic flush();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b in_ready=%b out_valid=%b required 1 0 1 0",
               empty, full, in_ready, out_valid);
    end
    checks++;
    if (count !== 3'd0 || out_data !== 6'sd0 || sat_count !== 8'd0 || ign_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_values: count=%0d out_data=%0d sat=%0d ign=%0d required all 0",
               count, out_data, sat_count, ign_count);
    end
  endtask

  task automatic test_fill_drain();
    logic signed [5:0] exp [5];
    logic acc;
    exp[0] = 6'sd5; exp[1] = -6'sd7; exp[2] = 6'sd30; exp[3] = -6'sd30; exp[4] = 6'sd12;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(exp[i]);
    in_valid = 1'b1;
    in_data  = 6'sd12;
    cyc();
    checks++;
    if (in_ready !== 1'b0 || full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_stall: in_ready=%b full=%b count=%0d required 0 1 4", in_ready, full, count);
    end
    checks++;
    if (sat_count !== 8'd2) begin
      errors++;
      $display("FAIL fill_sat: got %0d required 2", sat_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL drain_%0d: out_valid=%b out_data=%0d required 1 %0d", i, out_valid, out_data, exp[i]);
      end
      acc = in_valid && in_ready;
      cyc();
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 3'd0 || sat_count !== 8'd2) begin
      errors++;
      $display("FAIL drain_end: empty=%b count=%0d sat=%0d required 1 0 2", empty, count, sat_count);
    end
  endtask

  task automatic test_ignore();
    flush();
    out_ready = 1'b0;
    push(-6'sd32);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || ign_count !== 8'd1) begin
      errors++;
      $display("FAIL ign_first: count=%0d empty=%b ign=%0d required 0 1 1", count, empty, ign_count);
    end
    push(6'sd3);
    push(-6'sd32);
    checks++;
    if (count !== 3'd1 || ign_count !== 8'd2 || out_data !== 6'sd3) begin
      errors++;
      $display("FAIL ign_result: count=%0d ign=%0d out_data=%0d required 1 2 3", count, ign_count, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [5:0] exp [8];
    flush();
    out_ready = 1'b0;
    push(6'sd1);
    push(6'sd2);
    exp[0] = 6'sd1; exp[1] = 6'sd2;
    for (int i = 0; i < 6; i++) exp[i+2] = 6'(9 + i);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = exp[i+2];
      checks++;
      if (out_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_data_%0d: got %0d required %0d", i, out_data, exp[i]);
      end
      cyc();
      checks++;
      if (count !== 3'd2) begin
        errors++;
        $display("FAIL b2b_count_%0d: got %0d required 2", i, count);
      end
    end
    in_valid = 1'b0;
    for (int i = 6; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp[i]) begin
        errors++;
        $display("FAIL b2b_tail_%0d: out_valid=%b out_data=%0d required 1 %0d", i, out_valid, out_data, exp[i]);
      end
      cyc();
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_empty: got %b required 1", empty);
    end
  endtask

  task automatic test_saturation();
    flush();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = -6'sd32;
    for (int i = 0; i < 254; i++) cyc();
    checks++;
    if (ign_count !== 8'd254) begin
      errors++;
      $display("FAIL sat_254: got %0d required 254", ign_count);
    end
    cyc();
    checks++;
    if (ign_count !== 8'd255) begin
      errors++;
      $display("FAIL sat_255: got %0d required 255", ign_count);
    end
    for (int i = 0; i < 5; i++) cyc();
    checks++;
    if (ign_count !== 8'd255 || count !== 3'd0) begin
      errors++;
      $display("FAIL sat_hold: ign=%0d count=%0d required 255 0", ign_count, count);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    flush();
    out_ready = 1'b0;
    push(6'sd1);
    push(6'sd30);
    push(-6'sd32);
    push(6'sd2);
    checks++;
    if (count !== 3'd3 || sat_count !== 8'd1 || ign_count !== 8'd1) begin
      errors++;
      $display("FAIL flush_pre: count=%0d sat=%0d ign=%0d required 3 1 1", count, sat_count, ign_count);
    end
    clr = 1'b1; in_valid = 1'b1; in_data = 6'sd30; out_ready = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || sat_count !== 8'd0 || ign_count !== 8'd0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_result: count=%0d sat=%0d ign=%0d empty=%b required 0 0 0 1",
               count, sat_count, ign_count, empty);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 6'sd0) begin
      errors++;
      $display("FAIL flush_nostore: out_valid=%b out_data=%0d required 0 0", out_valid, out_data);
    end
  endtask

  task automatic test_reset_midrun();
    flush();
    out_ready = 1'b0;
    push(6'sd30);
    push(-6'sd32);
    push(6'sd4);
    push(6'sd5);
    checks++;
    if (count !== 3'd3 || sat_count !== 8'd1 || ign_count !== 8'd1) begin
      errors++;
      $display("FAIL midrst_pre: count=%0d sat=%0d ign=%0d required 3 1 1", count, sat_count, ign_count);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (empty !== 1'b1 || count !== 3'd0 || out_valid !== 1'b0 || out_data !== 6'sd0 ||
        sat_count !== 8'd0 || ign_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_async: empty=%b count=%0d out_valid=%b out_data=%0d sat=%0d ign=%0d required 1 0 0 0 0 0",
               empty, count, out_valid, out_data, sat_count, ign_count);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (empty !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_release: empty=%b in_ready=%b required 1 1", empty, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    test_reset();
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    test_fill_drain();
    test_ignore();
    test_back_to_back();
    test_saturation();
    test_flush();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
